// File: rtl/mips_hazard_pkg.sv
// Shared timing constants for the Tuse/Tnew hazard scoreboard.
// Controllers use these when pre-decoding operands for the D stage.
package mips_hazard_pkg;

  localparam int TW = 2;

  localparam logic [TW-1:0] TUSE_BR  = 2'd0;
  localparam logic [TW-1:0] TUSE_ALU = 2'd1;
  localparam logic [TW-1:0] TUSE_ST  = 2'd2;

  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_LD   = 2'd2;
  localparam logic [TW-1:0] TNEW_LINK = 2'd0;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage timing inputs and stall outputs of the hazard scoreboard.
// The master side is the pipeline controller; the slave side is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int TW    = mips_hazard_pkg::TW,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(NREG);

  logic             d_valid;
  logic [AW-1:0]    d_rs;
  logic             d_rs_use;
  logic [TW-1:0]    d_rs_tuse;
  logic [AW-1:0]    d_rt;
  logic             d_rt_use;
  logic [TW-1:0]    d_rt_tuse;
  logic [AW-1:0]    d_dst;
  logic [TW-1:0]    d_tnew;
  logic             d_md_acc;
  logic             d_md_start;
  logic             d_md_div;
  logic             flush;
  logic             stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rs_use, d_rs_tuse, d_rt, d_rt_use, d_rt_tuse,
           d_dst, d_tnew, d_md_acc, d_md_start, d_md_div, flush,
    input  stall, md_busy, stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rs_use, d_rs_tuse, d_rt, d_rt_use, d_rt_tuse,
           d_dst, d_tnew, d_md_acc, d_md_start, d_md_div, flush,
    output stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_src_match.sv
// Per-operand hazard check: the youngest in-flight writer of src decides
// whether its result is still further away than the operand's Tuse.
module hazard_src_match #(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = mips_hazard_pkg::TW
) (
  input  logic [AW-1:0]        src_i,
  input  logic                 src_use_i,
  input  logic [TW-1:0]        tuse_i,
  input  logic [STAGES-1:0]    ent_valid_i,
  input  logic [STAGES*AW-1:0] ent_dst_i,
  input  logic [STAGES*TW-1:0] ent_rem_i,
  output logic                 hazard_o
);
  logic found;
  logic late;

  always_comb begin
    found = 1'b0;
    late  = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      // First hit from E outward is the youngest writer; older ones are stale
      if (!found && ent_valid_i[k] && (ent_dst_i[k*AW +: AW] == src_i)) begin
        found = 1'b1;
        late  = ent_rem_i[k*TW +: TW] > tuse_i;
      end
    end
    hazard_o = src_use_i && (src_i != '0) && late;
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew stall unit for the 5-stage MIPS pipeline: tracks destinations in
// E..W, owns the HI/LO latency counter and counts stalled cycles.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int STAGES   = 3,
  parameter int TW       = mips_hazard_pkg::TW,
  parameter int MULT_LAT = mips_hazard_pkg::MULT_LAT,
  parameter int DIV_LAT  = mips_hazard_pkg::DIV_LAT,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int MW = $clog2(DIV_LAT + 1);

  logic [STAGES-1:0]         valid_q, valid_d;
  logic [STAGES-1:0][AW-1:0] dst_q, dst_d;
  logic [STAGES-1:0][TW-1:0] rem_q, rem_d;
  logic [MW-1:0]             md_q, md_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic rs_haz, rt_haz, md_haz, stall, issue;

  hazard_src_match #(.STAGES(STAGES), .AW(AW), .TW(TW)) u_rs (
    .src_i      (bus.d_rs),
    .src_use_i  (bus.d_rs_use & bus.d_valid),
    .tuse_i     (bus.d_rs_tuse),
    .ent_valid_i(valid_q),
    .ent_dst_i  (dst_q),
    .ent_rem_i  (rem_q),
    .hazard_o   (rs_haz)
  );

  hazard_src_match #(.STAGES(STAGES), .AW(AW), .TW(TW)) u_rt (
    .src_i      (bus.d_rt),
    .src_use_i  (bus.d_rt_use & bus.d_valid),
    .tuse_i     (bus.d_rt_tuse),
    .ent_valid_i(valid_q),
    .ent_dst_i  (dst_q),
    .ent_rem_i  (rem_q),
    .hazard_o   (rt_haz)
  );

  assign md_haz = bus.d_valid & bus.d_md_acc & (md_q != '0);
  assign stall  = rs_haz | rt_haz | md_haz;
  assign issue  = bus.d_valid & ~stall & ~bus.flush;

  always_comb begin
    valid_d = '0;
    dst_d   = '0;
    rem_d   = '0;
    if (!bus.flush) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        dst_d[k]   = dst_q[k-1];
        rem_d[k]   = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - 1'b1;
      end
      if (issue && (bus.d_dst != '0)) begin
        valid_d[0] = 1'b1;
        dst_d[0]   = bus.d_dst;
        rem_d[0]   = bus.d_tnew;
      end
    end

    // An issued mult/div keeps counting through a flush
    if (issue && bus.d_md_start) begin
      md_d = bus.d_md_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
    end else if (md_q != '0) begin
      md_d = md_q - 1'b1;
    end else begin
      md_d = '0;
    end

    cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      md_q    <= md_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.md_busy   = md_q != '0;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised stall-generation unit for the 5-stage MIPS pipeline; it replaces per-opcode hazard decoding with a Tuse/Tnew scoreboard.
- Consumes pre-decoded D-stage operand/destination timing.
- Tracks in-flight destinations through E/M/W in an internal shift register.
- Owns the multiply/divide latency counter, so no external busy/start is needed.
- Drives the D-stage freeze / E-stage bubble signal and a saturating stall-cycle counter.

Parameters:
NREG, 32, architectural register count; AW = clog2(NREG); register 0 is hard-wired zero.
STAGES, 3, tracked stages after D (index 0 = E ... STAGES-1 = W).
TW, 2, width of Tuse/Tnew fields.
MULT_LAT, 5, cycles HI/LO stay busy after a mult/multu issues.
DIV_LAT, 10, cycles HI/LO stay busy after a div/divu issues.
CNT_W, 32, stall counter width.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
d_valid  in  1  D holds a real instruction.
d_rs  in  AW  source 1 address.
d_rs_use  in  1  source 1 is read.
d_rs_tuse  in  TW  cycles from D until rs value is consumed (branch/jr=0, ALU=1, store data=2).
d_rt  in  AW  source 2 address.
d_rt_use  in  1  source 2 is read.
d_rt_tuse  in  TW  as d_rs_tuse for rt.
d_dst  in  AW  destination register (0 = none).
d_tnew  in  TW  cycles after entering E until result is forwardable (ALU/mfhi=1, load=2, jal=0).
d_md_acc  in  1  instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
d_md_start  in  1  instruction is mult/multu/div/divu.
d_md_div  in  1  with d_md_start: divide latency instead of multiply latency.
flush  in  1  discard the instruction entering E; clear all scoreboard entries.
stall  out  1  freeze PC/IF-D register, insert bubble into E.
md_busy  out  1  HI/LO counter non-zero.
stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Scoreboard entries: entry[k] = {valid, dst, rem}, k = 0..STAGES-1.
- Each cycle every entry shifts k -> k+1; entry[STAGES-1] drops.
- Each shifted rem = max(rem-1, 0).
- entry[0] loads {d_valid & ~stall & ~flush & dst!=0, d_dst, d_tnew}.
- If stall or flush, entry[0] becomes a bubble (valid=0).
- Operand hazard (src = rs or rt):
  - Applies when src_use & d_valid & src!=0.
  - Find the youngest (lowest k) valid entry with dst==src; older matches are ignored.
  - Hazard if that entry's rem > src_tuse.
  - No match: no hazard.
- MD counter (width clog2(DIV_LAT+1)):
  - Loads MULT_LAT or DIV_LAT on a cycle where d_valid & d_md_start & ~stall & ~flush.
  - Otherwise decrements to 0.
  - md_busy = counter != 0.
  - md hazard = d_valid & d_md_acc & md_busy.
- stall = rs hazard | rt hazard | md hazard. Purely combinational from current state and D inputs, so zero-latency.
- flush together with stall:
  - flush wins for the entry[0] load.
  - stall still asserts combinationally; the instruction stays in D.
- flush does not clear the MD counter: an issued mult/div completes.
- stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
- Reset: all entries valid=0, dst=0, rem=0; MD counter 0; stall_cnt 0. Hence stall=0 and md_busy=0 in the cycle after reset.
- Width rules:
  - Tuse/Tnew values above 2^TW-1 are not representable; the decoder must clamp.
  - rem never underflows.

Decomposition:
- Shared package mips_hazard_pkg: TW; Tuse constants (TUSE_BR=0, TUSE_ALU=1, TUSE_ST=2); Tnew constants (TNEW_ALU=1, TNEW_LD=2, TNEW_LINK=0); MULT_LAT/DIV_LAT defaults.
- One sub-module: hazard_src_match. It takes src, use, tuse and the flattened entry array, and returns hazard. It is instantiated twice (rs, rt).
- Opcode-to-timing decode stays in the controller, not in this block.

Test Plan:
- Load-use: lw $8 issued (dst=8, tnew=2), then D = addu reading $8 (tuse=1) -> stall=1 for exactly 1 cycle, then 0; stall_cnt=1.
- Branch after ALU: addu $5 in E (rem=1), D = beq $5 (tuse=0) -> stall=1 one cycle. Same beq with addu in M (rem=0) -> stall=0.
- Youngest match wins: ori $3 in M (rem=0), lw $3 in E (rem=2), D = sw reading $3 as data (tuse=2) -> stall=0. Same case with tuse=1 -> stall=1.
- Zero register: lw $0 followed by addu reading $0 -> stall=0 and no entry allocated.
- MD latency: div issued (DIV_LAT=10), then mflo in D -> stall=1 for 10 cycles, md_busy falls with it. Reusing with mult (MULT_LAT=5) -> 5 cycles.
- Reset/flush mid-operation: reset asserted during div busy with lw in E -> next cycle md_busy=0, stall=0, stall_cnt=0. flush with lw $8 in D -> dependent addu $8 next cycle sees no stall.
